// File: rtl/vdp_super_vram_arbiter_if.sv
// vdp_super_vram_arbiter_if: requester, display and SDRAM-side signals of the VRAM slot arbiter.
// Stats signals are only routed through the modports when VRAM_ARB_STATS_EN is defined.
interface vdp_super_vram_arbiter_if;
    logic [10:0] cx;
    logic        vdp_super;
    logic        disp_active;
    logic [16:0] disp_addr;
    logic [31:0] disp_rdata;
    logic        disp_valid;
    logic        cpu_req;
    logic        cpu_we;
    logic [16:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_be;
    logic        cpu_ack;
    logic [31:0] cpu_rdata;
    logic        cmd_req;
    logic        cmd_we;
    logic [16:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_be;
    logic        cmd_ack;
    logic [31:0] cmd_rdata;
    logic [16:0] vram_addr;
    logic [31:0] vram_wdata;
    logic [3:0]  vram_be;
    logic        vram_rd;
    logic        vram_wr;
    logic        vram_refresh;
    logic [31:0] vram_rdata;
    logic        stats_clear;
    logic [15:0] cpu_wait_cnt;
    logic [15:0] cmd_wait_cnt;

    modport slave (
`ifdef VRAM_ARB_STATS_EN
        input stats_clear, output cpu_wait_cnt, cmd_wait_cnt,
`endif
        input cx, vdp_super, disp_active, disp_addr,
        input cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
        input cmd_req, cmd_we, cmd_addr, cmd_wdata, cmd_be, vram_rdata,
        output disp_rdata, disp_valid, cpu_ack, cpu_rdata, cmd_ack, cmd_rdata,
        output vram_addr, vram_wdata, vram_be, vram_rd, vram_wr, vram_refresh
    );

    modport master (
`ifdef VRAM_ARB_STATS_EN
        output stats_clear, input cpu_wait_cnt, cmd_wait_cnt,
`endif
        output cx, vdp_super, disp_active, disp_addr,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
        output cmd_req, cmd_we, cmd_addr, cmd_wdata, cmd_be, vram_rdata,
        input disp_rdata, disp_valid, cpu_ack, cpu_rdata, cmd_ack, cmd_rdata,
        input vram_addr, vram_wdata, vram_be, vram_rd, vram_wr, vram_refresh
    );
endinterface

// File: rtl/vdp_super_vram_arbiter.sv
// vdp_super_vram_arbiter: cx-slotted scheduler for the shared VRAM port (display, CPU, command engine).
// Optional wait counters are built when VRAM_ARB_STATS_EN is defined.
module vdp_super_vram_arbiter #(
    parameter int          READ_LATENCY = 4,
    parameter logic [10:0] REFRESH_CX   = 11'd723
) (
    input logic clk,
    input logic reset,
    vdp_super_vram_arbiter_if.slave bus
);
    logic disp_slot, gen_slot, cpu_el, cmd_el, cpu_gnt, cmd_gnt;
    logic cpu_busy, cmd_busy, last_cmd;
    logic [2:0] tag, ret;
    logic [READ_LATENCY-1:0][2:0] pipe;

    always_comb begin
        disp_slot = bus.cx[1:0] == 2'd1 && bus.vdp_super && bus.disp_active;
        gen_slot  = (bus.cx[1:0] == 2'd3 && bus.cx != REFRESH_CX) || (bus.cx[1:0] == 2'd1 && !disp_slot);
        cpu_el    = gen_slot && bus.cpu_req && !cpu_busy;
        cmd_el    = gen_slot && bus.cmd_req && !cmd_busy;
        cpu_gnt   = cpu_el && (!cmd_el || last_cmd);
        cmd_gnt   = cmd_el && !cpu_gnt;
        ret       = pipe[READ_LATENCY-1];
    end

    assign bus.vram_refresh = !reset && bus.cx == REFRESH_CX;

    // Busy holds through the ack cycle so a requester still showing req then is not served twice.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.vram_addr  <= '0;
            bus.vram_wdata <= '0;
            bus.vram_be    <= '0;
            bus.vram_rd    <= 1'b0;
            bus.vram_wr    <= 1'b0;
            bus.cpu_ack    <= 1'b0;
            bus.cmd_ack    <= 1'b0;
            bus.disp_valid <= 1'b0;
            bus.cpu_rdata  <= '0;
            bus.cmd_rdata  <= '0;
            bus.disp_rdata <= '0;
            tag            <= '0;
            pipe           <= '0;
            cpu_busy       <= 1'b0;
            cmd_busy       <= 1'b0;
            last_cmd       <= 1'b1;
        end else begin
            bus.vram_rd <= disp_slot || (cpu_gnt && !bus.cpu_we) || (cmd_gnt && !bus.cmd_we);
            bus.vram_wr <= (cpu_gnt && bus.cpu_we) || (cmd_gnt && bus.cmd_we);
            if (disp_slot) begin
                bus.vram_addr <= bus.disp_addr;
            end else if (cpu_gnt) begin
                bus.vram_addr  <= bus.cpu_addr;
                bus.vram_wdata <= bus.cpu_wdata;
                bus.vram_be    <= bus.cpu_be;
            end else if (cmd_gnt) begin
                bus.vram_addr  <= bus.cmd_addr;
                bus.vram_wdata <= bus.cmd_wdata;
                bus.vram_be    <= bus.cmd_be;
            end
            tag  <= {disp_slot, cpu_gnt && !bus.cpu_we, cmd_gnt && !bus.cmd_we};
            pipe <= {pipe[READ_LATENCY-2:0], tag};
            bus.disp_valid <= ret[2];
            bus.cpu_ack    <= (cpu_gnt && bus.cpu_we) || ret[1];
            bus.cmd_ack    <= (cmd_gnt && bus.cmd_we) || ret[0];
            if (ret[2]) bus.disp_rdata <= bus.vram_rdata;
            if (ret[1]) bus.cpu_rdata <= bus.vram_rdata;
            if (ret[0]) bus.cmd_rdata <= bus.vram_rdata;
            cpu_busy <= cpu_gnt || (cpu_busy && !bus.cpu_ack);
            cmd_busy <= cmd_gnt || (cmd_busy && !bus.cmd_ack);
            if (cpu_gnt || cmd_gnt) last_cmd <= cmd_gnt;
        end
    end

`ifdef VRAM_ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.cpu_wait_cnt <= '0;
            bus.cmd_wait_cnt <= '0;
        end else if (bus.stats_clear) begin
            bus.cpu_wait_cnt <= '0;
            bus.cmd_wait_cnt <= '0;
        end else begin
            if (gen_slot && bus.cpu_req && !cpu_gnt && bus.cpu_wait_cnt != 16'hFFFF)
                bus.cpu_wait_cnt <= bus.cpu_wait_cnt + 16'd1;
            if (gen_slot && bus.cmd_req && !cmd_gnt && bus.cmd_wait_cnt != 16'hFFFF)
                bus.cmd_wait_cnt <= bus.cmd_wait_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_vdp_super_vram_arbiter.sv
// tb_vdp_super_vram_arbiter: random requesters checked against a cycle-scheduled reference model.
// Stats counters are checked too when VRAM_ARB_STATS_EN is defined.
module tb_vdp_super_vram_arbiter;
    localparam int L = 4;
    localparam int RCX = 723;
    localparam int LINE = 858;
    localparam int NCYC = 6000;

    typedef struct {
        bit act, gnt, we;
        bit [16:0] addr;
        bit [31:0] wdata;
        bit [3:0] be;
        int ack_at;
    } rq_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    vdp_super_vram_arbiter_if bus();
    vdp_super_vram_arbiter #(.READ_LATENCY(L), .REFRESH_CX(11'(RCX))) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit e_rd[32], e_wr[32], e_dv[32];
    bit e_ack[2][32], e_rk[2][32];
    bit [16:0] e_addr[32];
    bit [31:0] e_wdata[32], hist[32];
    bit [3:0] e_be[32];
    rq_t rq[2];
    int last = 1;
    int rst_at = -1;
    int wc[2];
    bit dw = 0;
    bit sup = 1, act = 1, clr = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        for (int n = 0; n < NCYC; n++) begin
            int k, cx, m, w, p, j, a;
            bit rst, own, gen;
            bit el[2];
            bit [16:0] daddr;
            @(negedge clk);
            k = n % 32;
            check("vram_rd", 64'(bus.vram_rd), 64'(e_rd[k]));
            check("vram_wr", 64'(bus.vram_wr), 64'(e_wr[k]));
            if (e_rd[k] || e_wr[k]) check("vram_addr", 64'(bus.vram_addr), 64'(e_addr[k]));
            if (e_wr[k]) begin
                check("vram_wdata", 64'(bus.vram_wdata), 64'(e_wdata[k]));
                check("vram_be", 64'(bus.vram_be), 64'(e_be[k]));
            end
            check("cpu_ack", 64'(bus.cpu_ack), 64'(e_ack[0][k]));
            check("cmd_ack", 64'(bus.cmd_ack), 64'(e_ack[1][k]));
            check("disp_valid", 64'(bus.disp_valid), 64'(e_dv[k]));
            if (e_rk[0][k]) check("cpu_rdata", 64'(bus.cpu_rdata), 64'(hist[(n + 31) % 32]));
            if (e_rk[1][k]) check("cmd_rdata", 64'(bus.cmd_rdata), 64'(hist[(n + 31) % 32]));
            if (e_dv[k]) check("disp_rdata", 64'(bus.disp_rdata), 64'(hist[(n + 31) % 32]));
`ifdef VRAM_ARB_STATS_EN
            check("cpu_wait_cnt", 64'(bus.cpu_wait_cnt), 64'(wc[0]));
            check("cmd_wait_cnt", 64'(bus.cmd_wait_cnt), 64'(wc[1]));
`endif
            {e_rd[k], e_wr[k], e_dv[k], e_ack[0][k], e_ack[1][k], e_rk[0][k], e_rk[1][k]} = '0;
            rst = n < 3 || (rst_at >= 0 && n >= rst_at && n < rst_at + 2);
            reset = rst;
            if (rst) begin
                for (int i = 0; i < 32; i++)
                    {e_rd[i], e_wr[i], e_dv[i], e_ack[0][i], e_ack[1][i], e_rk[0][i], e_rk[1][i]} = '0;
                rq[0] = '{default: 0};
                rq[1] = '{default: 0};
                last = 1;
                wc = '{0, 0};
            end
            cx = n % LINE;
            if (n < 1800) {sup, act} = 2'b11;
            else if (n < 3600) {sup, act} = 2'b10;
            else begin
                if ($urandom_range(199) == 0) sup = !sup;
                if (cx == 0) act = $urandom_range(1) == 1;
            end
            p = n < 1800 ? 50 : n < 3600 ? 100 : 25;
            for (int r = 0; r < 2; r++) begin
                if (rq[r].gnt && n > rq[r].ack_at) {rq[r].act, rq[r].gnt} = 2'b00;
                if (rst) continue;
                if (!rq[r].act && $urandom_range(99) < p) begin
                    rq[r].act = 1;
                    rq[r].we = $urandom_range(1) == 1;
                    rq[r].addr = 17'($urandom);
                    rq[r].wdata = $urandom;
                    rq[r].be = 4'($urandom);
                    if (r == 0 && !dw && n >= 1800) begin
                        dw = 1;
                        rq[r].we = 1;
                        rq[r].addr = 17'h1FFFF;
                        rq[r].wdata = 32'h12345678;
                        rq[r].be = 4'b0101;
                    end
                end else if (n >= 3600 && rq[r].act && !rq[r].gnt && $urandom_range(15) == 0) begin
                    rq[r].act = 0;
                end
            end
            daddr = 17'($urandom);
            hist[k] = $urandom;
            clr = n >= 3600 && $urandom_range(63) == 0;
            bus.cx = 11'(cx);
            bus.vdp_super = sup;
            bus.disp_active = act;
            bus.disp_addr = daddr;
            bus.vram_rdata = hist[k];
            bus.stats_clear = clr;
            {bus.cpu_req, bus.cpu_we, bus.cpu_addr, bus.cpu_wdata, bus.cpu_be} = {rq[0].act, rq[0].we, rq[0].addr, rq[0].wdata, rq[0].be};
            {bus.cmd_req, bus.cmd_we, bus.cmd_addr, bus.cmd_wdata, bus.cmd_be} = {rq[1].act, rq[1].we, rq[1].addr, rq[1].wdata, rq[1].be};
            #1;
            check("vram_refresh", 64'(bus.vram_refresh), 64'(!rst && cx == RCX));
            if (rst) begin
                check("rst_vram_addr", 64'(bus.vram_addr), 64'd0);
                check("rst_vram_wdata", 64'(bus.vram_wdata), 64'd0);
                check("rst_vram_be", 64'(bus.vram_be), 64'd0);
                check("rst_cpu_rdata", 64'(bus.cpu_rdata), 64'd0);
                check("rst_cmd_rdata", 64'(bus.cmd_rdata), 64'd0);
                check("rst_disp_rdata", 64'(bus.disp_rdata), 64'd0);
                check("rst_strobes", 64'({bus.vram_rd, bus.vram_wr, bus.cpu_ack, bus.cmd_ack, bus.disp_valid}), 64'd0);
`ifdef VRAM_ARB_STATS_EN
                check("rst_wait_cnt", 64'({bus.cpu_wait_cnt, bus.cmd_wait_cnt}), 64'd0);
`endif
                continue;
            end
            m = cx % 4;
            own = m == 1 && sup && act;
            gen = (m == 3 && cx != RCX) || (m == 1 && !own);
            for (int r = 0; r < 2; r++) el[r] = gen && rq[r].act && !rq[r].gnt;
            w = (el[0] && el[1]) ? (last == 0 ? 1 : 0) : el[0] ? 0 : el[1] ? 1 : -1;
            j = (n + 1) % 32;
            a = (n + L + 2) % 32;
            if (own) begin
                e_rd[j] = 1;
                e_addr[j] = daddr;
                e_dv[a] = 1;
            end else if (w >= 0) begin
                last = w;
                rq[w].gnt = 1;
                e_addr[j] = rq[w].addr;
                if (rq[w].we) begin
                    e_wr[j] = 1;
                    e_wdata[j] = rq[w].wdata;
                    e_be[j] = rq[w].be;
                    e_ack[w][j] = 1;
                    rq[w].ack_at = n + 1;
                end else begin
                    e_rd[j] = 1;
                    e_ack[w][a] = 1;
                    e_rk[w][a] = 1;
                    rq[w].ack_at = n + L + 2;
                    if (w == 0 && n >= 5200 && rst_at < 0) rst_at = n + 2;
                end
            end
            for (int r = 0; r < 2; r++) begin
                if (gen && rq[r].act && w != r && wc[r] < 65535) wc[r]++;
                if (clr) wc[r] = 0;
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vdp_super_vram_arbiter.md
Name: vdp_super_vram_arbiter

Overview:
Slot scheduler for the shared 32-bit VRAM/SDRAM port used by super-res display fetch, the CPU port and the command engine. Slots are derived from the horizontal counter cx, with one refresh slot per line. Display fetch has absolute priority in its slot; CPU and command engine share the remaining slots round-robin. The block sits between the requesters and the SDRAM controller and returns read data tagged to the correct requester.

Parameters:
READ_LATENCY, 4, clocks from issue cycle to vram_rdata valid (range 2..7)
REFRESH_CX, 723, cx value of the per-line refresh slot (must have cx[1:0]==3)

Ports:
clk  in  1  system clock
reset  in  1  reset, asynchronous, active-high
cx  in  11  horizontal pixel counter
vdp_super  in  1  super-res mode enabled
disp_active  in  1  display fetch needs its slot this line (super_res_drawing)
disp_addr  in  17  display fetch word address
disp_rdata  out  32  display read data
disp_valid  out  1  one-cycle strobe, disp_rdata valid
cpu_req  in  1  CPU request, held until cpu_ack
cpu_we  in  1  1=write, 0=read
cpu_addr  in  17  CPU word address
cpu_wdata  in  32  CPU write data
cpu_be  in  4  CPU byte enables
cpu_ack  out  1  one-cycle completion strobe
cpu_rdata  out  32  CPU read data, valid with cpu_ack on reads
cmd_req, cmd_we, cmd_addr, cmd_wdata, cmd_be, cmd_ack, cmd_rdata  as CPU equivalents for the command engine
vram_addr  out  17  address to SDRAM controller
vram_wdata  out  32  write data
vram_be  out  4  byte enables
vram_rd  out  1  read strobe
vram_wr  out  1  write strobe
vram_refresh  out  1  refresh strobe
vram_rdata  in  32  read data from SDRAM controller

Behaviour:
- Reset: all strobes (vram_rd/wr/refresh, cpu_ack, cmd_ack, disp_valid) 0; vram_addr/wdata/be, all rdata outputs 0; the in-flight pipeline and the round-robin pointer (first winner = CPU) are cleared.
- Slot cycles: cx[1:0]==1 is the display slot; cx[1:0]==3 is the general slot. Cycles with cx[1:0]=0/2 issue nothing.
- Refresh: when cx==REFRESH_CX, assert vram_refresh for 1 cycle. No grant is issued in that slot; it overrides all requesters.
- Display slot: if vdp_super & disp_active, issue a read of disp_addr. Otherwise the slot is treated as a general slot.
- General slot: eligible requesters are those with req high at that clock edge, including a req that rose in that same cycle.
  - One eligible requester: it is granted.
  - Both eligible: grant the one not granted last; the pointer updates only on a grant.
- Issue: registered. Outputs (vram_addr, wdata, be, rd/wr) are driven in the cycle after the slot cycle, with rd/wr high for exactly 1 cycle.
- Write ack: *_ack pulses in the same cycle as vram_wr.
- Read ack: a 3-bit tag {none, disp, cpu, cmd} enters a READ_LATENCY-deep shift register at issue. vram_rdata is captured into the tagged requester's rdata when the tag emerges, and ack/valid pulses in that same cycle.
- A granted requester is not re-granted until its ack has been produced. This allows at most one outstanding access per requester.
- Requesters must not change addr/we/wdata/be between req and ack. The arbiter latches them at grant.
- req dropping before grant cancels the request silently; no ack is generated.
- vdp_super falling mid-line: the display slot becomes general from the next slot; display reads already in flight still complete with disp_valid.
- Reset asserted mid-operation: in-flight reads are discarded and no ack is produced after reset.
- Address/width: all addresses are 17-bit word addresses and pass through unmodified; there is no wrap or arithmetic.

Optional Feature:
VRAM_ARB_STATS_EN:
- Defined: adds a stats_clear input (1 bit) and outputs cpu_wait_cnt and cmd_wait_cnt (16 bits each).
  - Each counter increments in every general slot in which its req is high but it is not granted.
  - Counters saturate at 0xFFFF.
  - stats_clear or reset zeroes both counters; clear wins over a same-cycle increment.
- Undefined: these ports and the counter logic are absent, and behaviour is otherwise identical.

Test Plan:
- Display only: vdp_super=1, disp_active=1, disp_addr=0x00010 at cx=841 -> vram_rd at cx=842 with addr 0x00010; vram_rdata=0xDEADBEEF four cycles later -> disp_rdata=0xDEADBEEF with disp_valid pulse.
- Refresh: cx sweeps 720..727 with cpu_req held -> vram_refresh only at cx=723, CPU not granted until the general slot at cx=727.
- Contention: cpu_req and cmd_req held continuously with disp_active=0 -> grants alternate CPU, CMD, CPU, CMD, with no slot granting either requester twice in a row.
- Display priority: disp_active=1 with cpu_req held -> every cx[1:0]==1 slot is a display read, and CPU is served only in cx[1:0]==3 slots.
- CPU write: cpu_we=1, addr 0x1FFFF, wdata 0x12345678, be 4'b0101 -> one vram_wr with identical fields, and cpu_ack in the same cycle.
- Reset mid-read: CPU read issued, then reset pulsed before READ_LATENCY expires -> no cpu_ack, all outputs 0; with VRAM_ARB_STATS_EN, counters read 0.
